// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared types and constants for the two-player fighter datapath
//
// Contents: FSM encoding for the combat resolver, winner codes, health and
// screen coordinate widths, default health/damage values (also read by the
// HUD health bar), and a saturating health subtract.
package fighter_pkg;

    localparam int HEALTH_W = 7;
    localparam int COORD_W  = 10;

    localparam logic [HEALTH_W-1:0] HP_MAX_DEFAULT = 7'd100;
    localparam logic [HEALTH_W-1:0] DAMAGE_DEFAULT = 7'd10;

    typedef enum logic {
        ST_FIGHT = 1'b0,
        ST_KO    = 1'b1
    } fight_state_t;

    typedef logic [1:0] winner_t;

    localparam winner_t WINNER_NONE = 2'b00;
    localparam winner_t WINNER_P1   = 2'b01;
    localparam winner_t WINNER_P2   = 2'b10;
    localparam winner_t WINNER_DRAW = 2'b11;

    // Health never wraps: a hit larger than the remaining health lands on zero.
    function automatic logic [HEALTH_W-1:0] sat_sub(
        input logic [HEALTH_W-1:0] a,
        input logic [HEALTH_W-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/hit_detect.sv
// rtl/hit_detect.sv - combinational attacker-to-defender reach test
//
// Ports:
//   atk_x, atk_y       attacker sprite anchor
//   atk_facing_right   attacker facing
//   def_x, def_y       defender sprite anchor
//   in_reach           defender is ahead of the attacker within HIT_RANGE and
//                      vertically within HIT_HEIGHT
module hit_detect
    import fighter_pkg::*;
#(
    parameter logic [COORD_W-1:0] HIT_RANGE  = 10'd40,
    parameter logic [COORD_W-1:0] HIT_HEIGHT = 10'd48
) (
    input  logic [COORD_W-1:0] atk_x,
    input  logic [COORD_W-1:0] atk_y,
    input  logic               atk_facing_right,
    input  logic [COORD_W-1:0] def_x,
    input  logic [COORD_W-1:0] def_y,
    output logic               in_reach
);

    // One extra bit keeps the differences of two unsigned coordinates exact.
    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic signed [COORD_W:0] dy_abs;

    always_comb begin
        if (atk_facing_right) begin
            dx = $signed({1'b0, def_x}) - $signed({1'b0, atk_x});
        end else begin
            dx = $signed({1'b0, atk_x}) - $signed({1'b0, def_x});
        end
        dy       = $signed({1'b0, atk_y}) - $signed({1'b0, def_y});
        dy_abs   = dy[COORD_W] ? -dy : dy;
        // A defender behind the attacker (negative dx) is never hit.
        in_reach = !dx[COORD_W]
                && (dx <= $signed({1'b0, HIT_RANGE}))
                && (dy_abs <= $signed({1'b0, HIT_HEIGHT}));
    end

endmodule

// File: rtl/combat_resolver.sv
// rtl/combat_resolver.sv - per-frame hit resolution, health, hitstun and KO
//
// Ports:
//   clk, reset                  pixel clock, synchronous active-high reset
//   SCEN                        one-clk frame tick; all state advances only here
//   pN_pos_x, pN_pos_y          player anchors
//   pN_facing_right             player facing
//   pN_attack_active            whole attack animation
//   pN_attack_damage            hitbox window
//   pN_health                   current health
//   pN_hitstun                  player is in hitstun
//   pN_hit_pulse                one clk after the tick on which the player is hit
//   game_over, winner           KO reached; 00 none, 01 P1, 10 P2, 11 draw
module combat_resolver
    import fighter_pkg::*;
#(
    parameter logic [HEALTH_W-1:0] HP_MAX         = HP_MAX_DEFAULT,
    parameter logic [HEALTH_W-1:0] DAMAGE         = DAMAGE_DEFAULT,
    parameter logic [4:0]          HITSTUN_FRAMES = 5'd12,
    parameter logic [COORD_W-1:0]  HIT_RANGE      = 10'd40,
    parameter logic [COORD_W-1:0]  HIT_HEIGHT     = 10'd48
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SCEN,
    input  logic [COORD_W-1:0]  p1_pos_x,
    input  logic [COORD_W-1:0]  p1_pos_y,
    input  logic [COORD_W-1:0]  p2_pos_x,
    input  logic [COORD_W-1:0]  p2_pos_y,
    input  logic                p1_facing_right,
    input  logic                p2_facing_right,
    input  logic                p1_attack_active,
    input  logic                p2_attack_active,
    input  logic                p1_attack_damage,
    input  logic                p2_attack_damage,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_hitstun,
    output logic                p2_hitstun,
    output logic                p1_hit_pulse,
    output logic                p2_hit_pulse,
    output logic                game_over,
    output winner_t             winner
);

    fight_state_t        state_q, state_d;
    winner_t             winner_q, winner_d;
    logic [HEALTH_W-1:0] p1_health_q, p1_health_d, p2_health_q, p2_health_d;
    logic [4:0]          p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;
    logic                p1_latch_q, p1_latch_d, p2_latch_q, p2_latch_d;
    logic                p1_pulse_q, p1_pulse_d, p2_pulse_q, p2_pulse_d;

    logic p1_in_reach, p2_in_reach;   // pN_in_reach: pN's attack reaches the other player
    logic p1_connect, p2_connect;     // pN_connect: pN lands a hit this tick

    hit_detect #(.HIT_RANGE(HIT_RANGE), .HIT_HEIGHT(HIT_HEIGHT)) u_p1_on_p2 (
        .atk_x            (p1_pos_x),
        .atk_y            (p1_pos_y),
        .atk_facing_right (p1_facing_right),
        .def_x            (p2_pos_x),
        .def_y            (p2_pos_y),
        .in_reach         (p1_in_reach)
    );

    hit_detect #(.HIT_RANGE(HIT_RANGE), .HIT_HEIGHT(HIT_HEIGHT)) u_p2_on_p1 (
        .atk_x            (p2_pos_x),
        .atk_y            (p2_pos_y),
        .atk_facing_right (p2_facing_right),
        .def_x            (p1_pos_x),
        .def_y            (p1_pos_y),
        .in_reach         (p2_in_reach)
    );

    // Both connects look only at pre-tick state, so a trade applies both hits.
    always_comb begin
        p1_connect = SCEN && (state_q == ST_FIGHT) && p1_attack_damage && p1_in_reach
                  && !p1_latch_q && (p2_cnt_q == 5'd0);
        p2_connect = SCEN && (state_q == ST_FIGHT) && p2_attack_damage && p2_in_reach
                  && !p2_latch_q && (p1_cnt_q == 5'd0);
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_cnt_d    = p1_cnt_q;
        p2_cnt_d    = p2_cnt_q;
        p1_latch_d  = p1_latch_q;
        p2_latch_d  = p2_latch_q;
        p1_pulse_d  = 1'b0;
        p2_pulse_d  = 1'b0;

        if (SCEN) begin
            // The latch stays set until the attack animation ends, so a long
            // hitbox window lands only once.
            p1_latch_d = p1_connect || (p1_latch_q && p1_attack_active);
            p2_latch_d = p2_connect || (p2_latch_q && p2_attack_active);

            if (p1_connect) begin
                p2_health_d = sat_sub(p2_health_q, DAMAGE);
                p2_cnt_d    = HITSTUN_FRAMES;
            end else if (p2_cnt_q != 5'd0) begin
                p2_cnt_d = p2_cnt_q - 5'd1;
            end

            if (p2_connect) begin
                p1_health_d = sat_sub(p1_health_q, DAMAGE);
                p1_cnt_d    = HITSTUN_FRAMES;
            end else if (p1_cnt_q != 5'd0) begin
                p1_cnt_d = p1_cnt_q - 5'd1;
            end

            p2_pulse_d = p1_connect;
            p1_pulse_d = p2_connect;

            if ((state_q == ST_FIGHT) && ((p1_health_d == '0) || (p2_health_d == '0))) begin
                state_d = ST_KO;
                if ((p1_health_d == '0) && (p2_health_d == '0)) begin
                    winner_d = WINNER_DRAW;
                end else if (p2_health_d == '0) begin
                    winner_d = WINNER_P1;
                end else begin
                    winner_d = WINNER_P2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FIGHT;
            winner_q    <= WINNER_NONE;
            p1_health_q <= HP_MAX;
            p2_health_q <= HP_MAX;
            p1_cnt_q    <= 5'd0;
            p2_cnt_q    <= 5'd0;
            p1_latch_q  <= 1'b0;
            p2_latch_q  <= 1'b0;
            p1_pulse_q  <= 1'b0;
            p2_pulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_cnt_q    <= p1_cnt_d;
            p2_cnt_q    <= p2_cnt_d;
            p1_latch_q  <= p1_latch_d;
            p2_latch_q  <= p2_latch_d;
            p1_pulse_q  <= p1_pulse_d;
            p2_pulse_q  <= p2_pulse_d;
        end
    end

    assign p1_health    = p1_health_q;
    assign p2_health    = p2_health_q;
    assign p1_hitstun   = (p1_cnt_q != 5'd0);
    assign p2_hitstun   = (p2_cnt_q != 5'd0);
    assign p1_hit_pulse = p1_pulse_q;
    assign p2_hit_pulse = p2_pulse_q;
    assign game_over    = (state_q == ST_KO);
    assign winner       = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// tb/tb_combat_resolver.sv - scoreboard bench for combat_resolver (DAMAGE 10 and DAMAGE 30 instances)
module tb_combat_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCEN;
    logic [9:0] p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y;
    logic       p1_facing_right, p2_facing_right;
    logic       p1_attack_active, p2_attack_active;
    logic       p1_attack_damage, p2_attack_damage;

    logic [6:0] a_p1_health, a_p2_health, b_p1_health, b_p2_health;
    logic       a_p1_hitstun, a_p2_hitstun, b_p1_hitstun, b_p2_hitstun;
    logic       a_p1_hit_pulse, a_p2_hit_pulse, b_p1_hit_pulse, b_p2_hit_pulse;
    logic       a_game_over, b_game_over;
    logic [1:0] a_winner, b_winner;

    always #5 clk = ~clk;

    combat_resolver dut_a (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .p1_pos_x(p1_pos_x), .p1_pos_y(p1_pos_y), .p2_pos_x(p2_pos_x), .p2_pos_y(p2_pos_y),
        .p1_facing_right(p1_facing_right), .p2_facing_right(p2_facing_right),
        .p1_attack_active(p1_attack_active), .p2_attack_active(p2_attack_active),
        .p1_attack_damage(p1_attack_damage), .p2_attack_damage(p2_attack_damage),
        .p1_health(a_p1_health), .p2_health(a_p2_health),
        .p1_hitstun(a_p1_hitstun), .p2_hitstun(a_p2_hitstun),
        .p1_hit_pulse(a_p1_hit_pulse), .p2_hit_pulse(a_p2_hit_pulse),
        .game_over(a_game_over), .winner(a_winner)
    );

    combat_resolver #(.DAMAGE(7'd30)) dut_b (
        .clk(clk), .reset(reset), .SCEN(SCEN),
        .p1_pos_x(p1_pos_x), .p1_pos_y(p1_pos_y), .p2_pos_x(p2_pos_x), .p2_pos_y(p2_pos_y),
        .p1_facing_right(p1_facing_right), .p2_facing_right(p2_facing_right),
        .p1_attack_active(p1_attack_active), .p2_attack_active(p2_attack_active),
        .p1_attack_damage(p1_attack_damage), .p2_attack_damage(p2_attack_damage),
        .p1_health(b_p1_health), .p2_health(b_p2_health),
        .p1_hitstun(b_p1_hitstun), .p2_hitstun(b_p2_hitstun),
        .p1_hit_pulse(b_p1_hit_pulse), .p2_hit_pulse(b_p2_hit_pulse),
        .game_over(b_game_over), .winner(b_winner)
    );

    typedef struct {
        int h1, h2, c1, c2;
        bit l1, l2, ko, pu1, pu2;
        int win;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t sb_q[$];
    mdl_t ma, mb;
    int   total = 0;
    int   bad   = 0;
    int   p1_pulse_cnt, p2_pulse_cnt, p2_stun_frames, both_pulse_cnt;

    localparam mdl_t MDL_RESET = '{h1: 100, h2: 100, c1: 0, c2: 0, l1: 0, l2: 0,
                                   ko: 0, pu1: 0, pu2: 0, win: 0};

    function automatic bit reach(input int ax, input int ay, input bit fr, input int dxp, input int dyp);
        int d;
        int v;
        d = fr ? (dxp - ax) : (ax - dxp);
        v = ay - dyp;
        if (v < 0) v = -v;
        return (d >= 0) && (d <= 40) && (v <= 48);
    endfunction

    // Reference behaviour for one frame tick with the currently driven inputs.
    function automatic mdl_t step(input mdl_t m, input int dmg);
        mdl_t n;
        bit   hit12, hit21;
        n = m;
        hit12 = !m.ko && (p1_attack_damage == 1'b1) && !m.l1 && (m.c2 == 0)
             && reach(int'(p1_pos_x), int'(p1_pos_y), p1_facing_right, int'(p2_pos_x), int'(p2_pos_y));
        hit21 = !m.ko && (p2_attack_damage == 1'b1) && !m.l2 && (m.c1 == 0)
             && reach(int'(p2_pos_x), int'(p2_pos_y), p2_facing_right, int'(p1_pos_x), int'(p1_pos_y));
        n.h2  = hit12 ? ((m.h2 > dmg) ? m.h2 - dmg : 0) : m.h2;
        n.c2  = hit12 ? 12 : ((m.c2 > 0) ? m.c2 - 1 : 0);
        n.h1  = hit21 ? ((m.h1 > dmg) ? m.h1 - dmg : 0) : m.h1;
        n.c1  = hit21 ? 12 : ((m.c1 > 0) ? m.c1 - 1 : 0);
        n.l1  = hit12 || (m.l1 && (p1_attack_active == 1'b1));
        n.l2  = hit21 || (m.l2 && (p2_attack_active == 1'b1));
        n.pu2 = hit12;
        n.pu1 = hit21;
        if (!m.ko && ((n.h1 == 0) || (n.h2 == 0))) begin
            n.ko  = 1'b1;
            n.win = ((n.h1 == 0) && (n.h2 == 0)) ? 3 : ((n.h2 == 0) ? 1 : 2);
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        total++;
        assert (obs === 32'(expv)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cmp_dut(input string tag, input mdl_t m,
                           input logic [6:0] h1, input logic [6:0] h2,
                           input logic s1, input logic s2, input logic pu1, input logic pu2,
                           input logic go, input logic [1:0] w);
        chk({tag, ".p1_health"},  32'(h1),  m.h1);
        chk({tag, ".p2_health"},  32'(h2),  m.h2);
        chk({tag, ".p1_hitstun"}, 32'(s1),  int'(m.c1 != 0));
        chk({tag, ".p2_hitstun"}, 32'(s2),  int'(m.c2 != 0));
        chk({tag, ".p1_pulse"},   32'(pu1), int'(m.pu1));
        chk({tag, ".p2_pulse"},   32'(pu2), int'(m.pu2));
        chk({tag, ".game_over"},  32'(go),  int'(m.ko));
        chk({tag, ".winner"},     32'(w),   m.win);
    endtask

    task automatic frame();
        exp_t e;
        e.a = step(ma, 10);
        e.b = step(mb, 30);
        ma  = e.a;
        mb  = e.b;
        sb_q.push_back(e);
        @(negedge clk);
        SCEN = 1'b1;
        @(posedge clk);
        #1;
        SCEN = 1'b0;
        e = sb_q.pop_front();
        cmp_dut("a", e.a, a_p1_health, a_p2_health, a_p1_hitstun, a_p2_hitstun,
                a_p1_hit_pulse, a_p2_hit_pulse, a_game_over, a_winner);
        cmp_dut("b", e.b, b_p1_health, b_p2_health, b_p1_hitstun, b_p2_hitstun,
                b_p1_hit_pulse, b_p2_hit_pulse, b_game_over, b_winner);
        p1_pulse_cnt   += int'(a_p1_hit_pulse);
        p2_pulse_cnt   += int'(a_p2_hit_pulse);
        both_pulse_cnt += int'(a_p1_hit_pulse & a_p2_hit_pulse);
        p2_stun_frames += int'(a_p2_hitstun);
        @(posedge clk);
        #1;
        chk("a.p1_pulse_drop", 32'(a_p1_hit_pulse), 0);
        chk("a.p2_pulse_drop", 32'(a_p2_hit_pulse), 0);
        chk("b.p2_pulse_drop", 32'(b_p2_hit_pulse), 0);
    endtask

    task automatic do_reset(input logic with_scen);
        @(negedge clk);
        reset = 1'b1;
        SCEN  = with_scen;
        @(posedge clk);
        #1;
        reset = 1'b0;
        SCEN  = 1'b0;
        ma = MDL_RESET;
        mb = MDL_RESET;
        sb_q.delete();
        cmp_dut("rst_a", ma, a_p1_health, a_p2_health, a_p1_hitstun, a_p2_hitstun,
                a_p1_hit_pulse, a_p2_hit_pulse, a_game_over, a_winner);
        cmp_dut("rst_b", mb, b_p1_health, b_p2_health, b_p1_hitstun, b_p2_hitstun,
                b_p1_hit_pulse, b_p2_hit_pulse, b_game_over, b_winner);
    endtask

    task automatic pos(input int x1, input int y1, input logic f1,
                       input int x2, input int y2, input logic f2);
        p1_pos_x = 10'(x1); p1_pos_y = 10'(y1); p1_facing_right = f1;
        p2_pos_x = 10'(x2); p2_pos_y = 10'(y2); p2_facing_right = f2;
    endtask

    task automatic atk(input logic a1, input logic d1, input logic a2, input logic d2);
        p1_attack_active = a1; p1_attack_damage = d1;
        p2_attack_active = a2; p2_attack_damage = d2;
    endtask

    task automatic clear_counts();
        p1_pulse_cnt = 0; p2_pulse_cnt = 0; p2_stun_frames = 0; both_pulse_cnt = 0;
    endtask

    initial begin
        reset = 1'b1;
        SCEN  = 1'b0;
        pos(0, 0, 1'b0, 0, 0, 1'b0);
        atk(1'b0, 1'b0, 1'b0, 1'b0);
        clear_counts();
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // Long hitbox window lands once; hitstun lasts 12 frames.
        pos(200, 360, 1'b1, 230, 360, 1'b0);
        clear_counts();
        atk(1'b1, 1'b0, 1'b0, 1'b0); frame();
        atk(1'b1, 1'b1, 1'b0, 1'b0); repeat (7) frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); repeat (14) frame();
        chk("t1.p2_health", 32'(a_p2_health), 90);
        chk("t1.pulse_count", 32'(p2_pulse_cnt), 1);
        chk("t1.stun_frames", 32'(p2_stun_frames), 12);

        // Facing away, just out of range, and exactly at range.
        do_reset(1'b0);
        pos(200, 360, 1'b0, 230, 360, 1'b0);
        atk(1'b1, 1'b1, 1'b0, 1'b0); repeat (3) frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); frame();
        chk("t2.facing_left", 32'(a_p2_health), 100);
        pos(200, 360, 1'b1, 241, 360, 1'b0);
        atk(1'b1, 1'b1, 1'b0, 1'b0); repeat (3) frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); frame();
        chk("t2.x241", 32'(a_p2_health), 100);
        pos(200, 360, 1'b1, 240, 360, 1'b0);
        atk(1'b1, 1'b1, 1'b0, 1'b0); frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); frame();
        chk("t2.x240", 32'(a_p2_health), 90);

        // Vertical limit; inputs ignored without SCEN.
        do_reset(1'b0);
        pos(200, 360, 1'b1, 230, 300, 1'b0);
        atk(1'b1, 1'b1, 1'b0, 1'b0); repeat (2) frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); frame();
        chk("t3.dy60", 32'(a_p2_health), 100);
        pos(200, 360, 1'b1, 230, 312, 1'b0);
        atk(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("t3.no_scen_health", 32'(a_p2_health), 100);
        chk("t3.no_scen_pulse", 32'(a_p2_hit_pulse), 0);
        frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); frame();
        chk("t3.dy48", 32'(a_p2_health), 90);

        // Trade.
        do_reset(1'b0);
        pos(200, 360, 1'b1, 230, 360, 1'b0);
        clear_counts();
        atk(1'b1, 1'b1, 1'b1, 1'b1); frame();
        chk("t4.both_pulse_same_clk", 32'(both_pulse_cnt), 1);
        chk("t4.p1_health", 32'(a_p1_health), 90);
        chk("t4.p2_health", 32'(a_p2_health), 90);
        atk(1'b0, 1'b0, 1'b0, 1'b0); repeat (13) frame();

        // KO after ten hits; DAMAGE=30 instance saturates at the fourth.
        do_reset(1'b0);
        pos(200, 360, 1'b1, 230, 360, 1'b0);
        for (int i = 0; i < 10; i++) begin
            atk(1'b1, 1'b1, 1'b0, 1'b0); frame();
            atk(1'b0, 1'b0, 1'b0, 1'b0); repeat (12) frame();
        end
        chk("t5.p2_health", 32'(a_p2_health), 0);
        chk("t5.game_over", 32'(a_game_over), 1);
        chk("t5.winner", 32'(a_winner), 1);
        chk("t5.sat_health", 32'(b_p2_health), 0);
        chk("t5.sat_winner", 32'(b_winner), 1);
        clear_counts();
        atk(1'b1, 1'b1, 1'b0, 1'b0); frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); frame();
        chk("t5.ko_no_pulse", 32'(p2_pulse_cnt), 0);
        chk("t5.ko_health", 32'(a_p2_health), 0);

        // Reset out of KO with SCEN and an attack present, then mid-hitstun.
        atk(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        atk(1'b0, 1'b0, 1'b0, 1'b0); frame();
        atk(1'b1, 1'b1, 1'b0, 1'b0); frame();
        atk(1'b0, 1'b0, 1'b0, 1'b0); repeat (3) frame();
        chk("t6.stun_before_reset", 32'(a_p2_hitstun), 1);
        do_reset(1'b1);
        chk("t6.health_after_reset", 32'(a_p2_health), 100);
        chk("t6.stun_after_reset", 32'(a_p2_hitstun), 0);
        chk("t6.winner_after_reset", 32'(a_winner), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
